fp_mul_arbiter: RTL and testbench

Shares one combinational single-precision `fp_multiplier` between two requesters. It arbitrates between them round-robin, registers the winning operands, captures the product one cycle later, and returns it to the requester that issued it through a valid/ready handshake. The block sits between two client datapaths and the single multiplier instance, which it instantiates internally. At most one operation is in flight at a time.

---
 rtl/fp_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision multiplier between two
// requesters; one operation in flight, result returned over a valid/ready handshake.

module fp_multiplier (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p
);

   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [23:0] man_a;
   logic [23:0] man_b;
   logic [47:0] prod;
   logic [7:0]  exp_sum;
   logic [22:0] frac;

   assign exp_a = a[30:23];
   assign exp_b = b[30:23];
   assign man_a = {1'b1, a[22:0]};
   assign man_b = {1'b1, b[22:0]};
   assign prod  = {24'd0, man_a} * {24'd0, man_b};

   // 8'd129 is -127 modulo 256; the exponent is allowed to wrap.
   assign exp_sum = exp_a + exp_b + 8'd129 + {7'd0, prod[47]};
   assign frac    = prod[47] ? prod[46:24] : prod[45:23];

   always_comb begin
      p = {a[31] ^ b[31], exp_sum, frac};
      if (exp_a == 8'h00 || exp_b == 8'h00) begin
         p = 32'h0000_0000;
      end else if (exp_a == 8'hff || exp_b == 8'hff) begin
         p = 32'h7f80_0000;
      end
   end

endmodule

module fp_mul_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [31:0] resp_data,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

   state_e      state_q, state_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] result_q, result_d;
   logic        grant;
   logic [31:0] mul_p;

   fp_multiplier u_mul (
      .a (op_a_q),
      .b (op_b_q),
      .p (mul_p)
   );

   // On a tie the requester that did not win last time is served.
   assign grant = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      result_d     = result_q;
      req_ready    = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               req_ready[grant] = 1'b1;
               op_a_d           = grant ? req_a1 : req_a0;
               op_b_d           = grant ? req_b1 : req_b0;
               owner_d          = grant;
               last_grant_d     = grant;
               state_d          = StCalc;
            end
         end
         StCalc: begin
            result_d = mul_p;
            state_d  = StResp;
         end
         StResp: begin
            if (resp_ready[owner_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         op_a_q       <= 32'd0;
         op_b_q       <= 32'd0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         result_q     <= result_d;
      end
   end

   assign resp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_data  = result_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized and directed checks of fp_mul_arbiter against a transaction-level reference model.

module tb_fp_mul_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [31:0] resp_data;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   fp_mul_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   // Reference product: truncated mantissa product, zero beats inf, exponent wraps.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint unsigned ma, mb, p;
      int              e;
      logic [7:0]      e8;
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h0000_0000;
      if (a[30:23] == 8'hff || b[30:23] == 8'hff) return 32'h7f80_0000;
      ma = 64'(1 << 23) + 64'(a[22:0]);
      mb = 64'(1 << 23) + 64'(b[22:0]);
      p  = ma * mb;
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p >= (64'd1 << 47)) begin
         p = p >> 1;
         e = e + 1;
      end
      e8 = e[7:0];
      return {a[31] ^ b[31], e8, p[45:23]};
   endfunction

   function automatic logic [31:0] rnd_norm();
      logic [7:0] e;
      e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   function automatic logic [31:0] rnd_any();
      int         k;
      logic [7:0] e;
      k = $urandom_range(0, 7);
      if (k == 0) e = 8'h00;
      else if (k == 1) e = 8'hff;
      else e = 8'($urandom_range(1, 254));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      tick();
      tick();
      n_vec++;
      if (req_ready !== 2'b00) begin
         n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
      end
      n_vec++;
      if (resp_valid !== 2'b00) begin
         n_err++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid);
      end
      n_vec++;
      if (resp_data !== 32'd0) begin
         n_err++; $display("FAIL reset_resp_data: got %h expected 0", resp_data);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [1:0] rv_exp [4];
      logic       busy_exp [4];
      rv_exp   = '{2'b00, 2'b00, 2'b01, 2'b00};
      busy_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
      req_valid  = 2'b01;
      req_a0     = 32'h3f80_0000;
      req_b0     = 32'h3f80_0000;
      resp_ready = 2'b11;
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL single_req_ready: got %b expected 01", req_ready);
      end
      for (int c = 0; c < 4; c++) begin
         if (c > 0) #1;
         n_vec++;
         if (resp_valid !== rv_exp[c] || busy !== busy_exp[c]) begin
            n_err++;
            $display("FAIL single_cycle%0d: got resp_valid=%b busy=%b expected %b %b",
                     c, resp_valid, busy, rv_exp[c], busy_exp[c]);
         end
         if (rv_exp[c] != 2'b00) begin
            n_vec++;
            if (resp_data !== 32'h3f80_0000) begin
               n_err++; $display("FAIL single_data: got %h expected 3f800000", resp_data);
            end
         end
         tick();
         req_valid = 2'b00;
      end
   endtask

   task automatic run_op(input bit r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expd, input string name);
      logic [1:0] oh;
      oh         = r ? 2'b10 : 2'b01;
      req_valid  = oh;
      resp_ready = 2'b11;
      if (r) begin req_a1 = a; req_b1 = b; end
      else begin req_a0 = a; req_b0 = b; end
      #1;
      n_vec++;
      if (req_ready !== oh) begin
         n_err++; $display("FAIL %s_req_ready: got %b expected %b", name, req_ready, oh);
      end
      tick();
      req_valid = 2'b00;
      tick();
      n_vec++;
      if (resp_valid !== oh || resp_data !== expd) begin
         n_err++;
         $display("FAIL %s_resp: got valid=%b data=%h expected valid=%b data=%h",
                  name, resp_valid, resp_data, oh, expd);
      end
      tick();
   endtask

   task automatic test_arith();
      run_op(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40c0_0000, "arith_2x3");
      run_op(1'b1, 32'hbfc0_0000, 32'h4000_0000, 32'hc040_0000, "arith_neg");
   endtask

   task automatic test_special();
      run_op(1'b0, 32'h7f80_0000, 32'h4000_0000, 32'h7f80_0000, "spec_inf");
      run_op(1'b0, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, "spec_zero");
      run_op(1'b0, 32'h7f80_0000, 32'h0000_0000, 32'h0000_0000, "spec_inf_zero");
   endtask

   task automatic test_contention();
      logic [31:0] expd;
      logic [1:0]  oh;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         oh = (i % 2 == 1) ? 2'b10 : 2'b01;
         req_a0 = rnd_norm(); req_b0 = rnd_norm();
         req_a1 = rnd_norm(); req_b1 = rnd_norm();
         req_valid  = 2'b11;
         resp_ready = 2'b11;
         expd = (i % 2 == 1) ? ref_mul(req_a1, req_b1) : ref_mul(req_a0, req_b0);
         #1;
         n_vec++;
         if (req_ready !== oh) begin
            n_err++; $display("FAIL cont%0d_grant: got %b expected %b", i, req_ready, oh);
         end
         tick();
         req_a0 = rnd_norm(); req_b0 = rnd_norm();
         req_a1 = rnd_norm(); req_b1 = rnd_norm();
         #1;
         n_vec++;
         if (req_ready !== 2'b00) begin
            n_err++; $display("FAIL cont%0d_calc_ready: got %b expected 00", i, req_ready);
         end
         tick();
         n_vec++;
         if (resp_valid !== oh || resp_data !== expd || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL cont%0d_resp: got valid=%b data=%h ready=%b expected %b %h 00",
                     i, resp_valid, resp_data, req_ready, oh, expd);
         end
         tick();
      end
      req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      logic [31:0] expd;
      req_a0     = rnd_norm();
      req_b0     = rnd_norm();
      expd       = ref_mul(req_a0, req_b0);
      req_valid  = 2'b01;
      resp_ready = 2'b00;
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL bp_grant0: got %b expected 01", req_ready);
      end
      tick();
      req_valid = 2'b10;
      req_a1    = rnd_norm();
      req_b1    = rnd_norm();
      tick();
      for (int c = 0; c < 5; c++) begin
         resp_ready = 2'b10;
         #1;
         n_vec++;
         if (resp_valid !== 2'b01 || resp_data !== expd || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b expected 01 %h 00",
                     c, resp_valid, resp_data, req_ready, expd);
         end
         tick();
      end
      resp_ready = 2'b01;
      #1;
      n_vec++;
      if (resp_valid !== 2'b01) begin
         n_err++; $display("FAIL bp_release: got %b expected 01", resp_valid);
      end
      tick();
      expd = ref_mul(req_a1, req_b1);
      n_vec++;
      if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
         n_err++;
         $display("FAIL bp_idle_grant1: got valid=%b ready=%b expected 00 10",
                  resp_valid, req_ready);
      end
      resp_ready = 2'b11;
      tick();
      req_valid = 2'b00;
      tick();
      n_vec++;
      if (resp_valid !== 2'b10 || resp_data !== expd) begin
         n_err++;
         $display("FAIL bp_resp1: got valid=%b data=%h expected 10 %h",
                  resp_valid, resp_data, expd);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      logic [31:0] expd;
      req_a0     = rnd_norm();
      req_b0     = rnd_norm();
      req_valid  = 2'b01;
      resp_ready = 2'b11;
      tick();
      req_valid = 2'b00;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_calc_busy: got %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_data !== 32'd0 || req_ready !== 2'b00)
      begin
         n_err++;
         $display("FAIL rst_mid_async: got busy=%b valid=%b data=%h ready=%b expected 0 00 0 00",
                  busy, resp_valid, resp_data, req_ready);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_stale%0d: got valid=%b busy=%b expected 00 0",
                     c, resp_valid, busy);
         end
         tick();
      end
      req_a0 = rnd_norm(); req_b0 = rnd_norm();
      req_a1 = rnd_norm(); req_b1 = rnd_norm();
      expd   = ref_mul(req_a0, req_b0);
      req_valid = 2'b11;
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL rst_mid_tie: got %b expected 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      tick();
      n_vec++;
      if (resp_valid !== 2'b01 || resp_data !== expd) begin
         n_err++;
         $display("FAIL rst_mid_resp: got valid=%b data=%h expected 01 %h",
                  resp_valid, resp_data, expd);
      end
      tick();
   endtask

   // Transaction-level model: one outstanding op, tracked by its age since acceptance.
   task automatic test_random(input int cycles);
      bit          inflight;
      int          age;
      bit          own;
      bit          lastg;
      bit          g;
      logic [31:0] exp_res;
      logic [1:0]  exp_ready;
      logic [1:0]  exp_rv;
      do_reset();
      inflight = 0; age = 0; own = 0; lastg = 1; g = 0; exp_res = '0;
      for (int c = 0; c < cycles; c++) begin
         req_valid  = 2'($urandom_range(0, 3));
         resp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         req_a0 = rnd_any(); req_b0 = rnd_any();
         req_a1 = rnd_any(); req_b1 = rnd_any();
         #1;
         exp_ready = 2'b00;
         exp_rv    = 2'b00;
         if (!inflight && req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? !lastg : req_valid[1];
            exp_ready[g] = 1'b1;
         end else if (inflight && age >= 2) begin
            exp_rv[own] = 1'b1;
         end
         n_vec++;
         if (req_ready !== exp_ready || resp_valid !== exp_rv || busy !== inflight) begin
            n_err++;
            $display("FAIL rand%0d: got ready=%b valid=%b busy=%b expected %b %b %b",
                     c, req_ready, resp_valid, busy, exp_ready, exp_rv, inflight);
         end
         if (exp_rv != 2'b00) begin
            n_vec++;
            if (resp_data !== exp_res) begin
               n_err++;
               $display("FAIL rand%0d_data: got %h expected %h", c, resp_data, exp_res);
            end
         end
         if (!inflight && req_valid != 2'b00) begin
            inflight = 1;
            age      = 1;
            own      = g;
            lastg    = g;
            exp_res  = g ? ref_mul(req_a1, req_b1) : ref_mul(req_a0, req_b0);
         end else if (inflight) begin
            if (age >= 2 && resp_ready[own]) inflight = 0;
            else if (age < 2) age++;
         end
         tick();
      end
      req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_arith();
      test_special();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
